am_demod_scheduler: RTL and testbench
=====================================

Name: am_demod_scheduler

Overview:
- Time-shares one free-running, fully pipelined AM magnitude datapath (sqrt(I^2+Q^2), fixed latency, one sample per cycle, no enable) between NUM_CH channel requesters.
- Arbitrates round-robin, issues at most one I/Q pair per cycle, tracks a channel tag alongside each sample, and returns the result tagged with its source channel.
- Sits between the per-channel DDC/decimator outputs and the shared demodulator instance.

Parameters:
- DATA_WIDTH, 12, I/Q sample width (signed); the result is DATA_WIDTH+1 bits unsigned.
- NUM_CH, 4, number of requesting channels (2..16).
- LATENCY, 5, clock edges from the datapath input changing to dp_result being valid.
- CH_W, $clog2(NUM_CH), channel index width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_CH  per-channel sample valid.
- req_ready  out  NUM_CH  per-channel accept; one-hot or zero.
- req_i  in  NUM_CH*DATA_WIDTH  signed I per channel; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_q  in  NUM_CH*DATA_WIDTH  signed Q per channel, packed the same way as req_i.
- ch_enable  in  NUM_CH  channel mask; a disabled channel is never granted.
- flush  in  1  synchronous discard of all in-flight samples.
- dp_inphase  out  DATA_WIDTH  to datapath I input, registered.
- dp_quadrature  out  DATA_WIDTH  to datapath Q input, registered.
- dp_result  in  DATA_WIDTH+1  datapath magnitude output.
- res_valid  out  1  result strobe, one cycle per accepted sample.
- res_ch  out  CH_W  source channel of the result.
- res_data  out  DATA_WIDTH+1  magnitude result.
- busy  out  1  high while any sample is in flight.

Behaviour:
- Reset clears every output and register to 0: req_ready, dp_inphase, dp_quadrature, res_valid, res_ch, res_data, busy, all tag stages and the round-robin pointer. After reset, channel 0 has the highest priority.
- Eligibility: channel k is eligible when req_valid[k] & ch_enable[k] & !flush.
- Grant: combinational, one-hot. It goes to the first eligible channel searching upward from ptr, wrapping modulo NUM_CH. req_ready[k] is 1 only for the granted channel.
- Handshake: a transfer occurs when req_valid[k] & req_ready[k] are high at a rising edge E. At E:
  - dp_inphase/dp_quadrature load that channel's I/Q;
  - ptr loads (k+1) mod NUM_CH;
  - a tag {valid=1, ch=k} enters the tag pipeline.
- With no grant: ptr holds, dp_inphase/dp_quadrature load 0, and an invalid tag enters the pipeline.
- Tag pipeline: a shift register of depth LATENCY+1 that shifts every cycle, with no stalls.
- Result timing: for a transfer at edge E, res_valid=1, res_ch=k and res_data=dp_result sampled at edge E+LATENCY+1, all held for exactly one cycle. Total request-to-result latency is LATENCY+1 edges.
- Results return in grant order. There is no result backpressure; the consumer must accept one result per cycle.
- Throughput: one transfer per cycle sustained. Full load on all channels gives grants in order 0,1,…,NUM_CH-1,0,…
- A single requester may be granted on consecutive cycles when no other channel is eligible.
- busy is a registered OR of all tag-valid bits, including the output stage.
- flush: while high, no grants are made. At the edge it is sampled, all tag-valid bits clear, and no res_valid is produced for any sample accepted before that edge. ptr and dp_* behave as in a no-grant cycle. Flush and a pending request in the same cycle: flush wins and the request stays pending.
- ch_enable change: takes effect for the grant in the same cycle. Samples already in flight still complete.
- rst mid-operation: all in-flight samples are lost immediately and asynchronously; no res_valid is produced after rst deasserts until new transfers complete.
- Arithmetic: the block does no arithmetic on data. I/Q pass unchanged (signed); dp_result passes unchanged (unsigned).

Test Plan:
- Single channel: ch0 I=3, Q=4 accepted at edge E -> res_valid pulses exactly once at E+6 with res_ch=0, res_data=5; busy high from E through E+5 and low after E+6.
- Corner value: ch2 I=-2048, Q=-2048 -> res_data=2896, res_ch=2.
- Full load: all 4 channels valid for 8 cycles, ch k driving I=k+1, Q=0 -> grants 0,1,2,3,0,1,2,3; results 1,2,3,4,1,2,3,4 on consecutive cycles with matching res_ch.
- Fairness and mask: ch1 and ch3 always valid, ch_enable=4'b0111 -> only ch1 ever granted; switch ch_enable to 4'b1111 -> ch1 and ch3 alternate.
- Flush: 3 transfers issued, flush pulsed 2 cycles later -> zero res_valid pulses from those transfers; a transfer after flush deasserts returns normally 6 edges later.
- Reset mid-flight: assert rst asynchronously (between edges) while 4 samples are in flight -> all outputs read 0 immediately; no res_valid pulses afterwards; ptr restarts with ch0 first.

Source files
------------

// File: rtl/am_demod_scheduler_if.sv
// Request, datapath and result signals shared by the AM demod scheduler and its neighbours.
// slave = scheduler side; master = requesters, datapath and result consumer.
interface am_demod_scheduler_if #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_CH     = 4
);
   localparam int CH_W = $clog2(NUM_CH);

   logic        [NUM_CH-1:0]            req_valid;
   logic        [NUM_CH-1:0]            req_ready;
   logic        [NUM_CH*DATA_WIDTH-1:0] req_i;
   logic        [NUM_CH*DATA_WIDTH-1:0] req_q;
   logic        [NUM_CH-1:0]            ch_enable;
   logic                                flush;
   logic signed [DATA_WIDTH-1:0]        dp_inphase;
   logic signed [DATA_WIDTH-1:0]        dp_quadrature;
   logic        [DATA_WIDTH:0]          dp_result;
   logic                                res_valid;
   logic        [CH_W-1:0]              res_ch;
   logic        [DATA_WIDTH:0]          res_data;
   logic                                busy;

   modport slave (
      input  req_valid, req_i, req_q, ch_enable, flush, dp_result,
      output req_ready, dp_inphase, dp_quadrature, res_valid, res_ch, res_data, busy
   );

   modport master (
      output req_valid, req_i, req_q, ch_enable, flush, dp_result,
      input  req_ready, dp_inphase, dp_quadrature, res_valid, res_ch, res_data, busy
   );
endinterface

// File: rtl/am_demod_scheduler.sv
// Round-robin share of one fixed-latency AM magnitude datapath; results tagged, LATENCY+1 edges after grant.
// Requesters see one-hot req_ready; results carry no backpressure, flush drops everything in flight.
module am_demod_scheduler #(
   parameter int DATA_WIDTH = 12,
   parameter int NUM_CH     = 4,
   parameter int LATENCY    = 5
) (
   input  logic              clk,
   input  logic              rst,
   am_demod_scheduler_if.slave bus
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [CH_W-1:0]         ptr;
   logic [NUM_CH-1:0]       elig;
   logic [NUM_CH-1:0]       elig_rot;
   logic                    gnt_any;
   logic [CH_W-1:0]         gnt_off;
   logic [CH_W:0]           gnt_sum;
   logic [CH_W-1:0]         gnt_ch;
   logic [DATA_WIDTH-1:0]   sel_i;
   logic [DATA_WIDTH-1:0]   sel_q;
   logic [LATENCY:0]        tag_vld;
   logic [LATENCY:0]        tag_vld_nxt;
   logic [CH_W-1:0]         tag_ch [0:LATENCY];

   // rst gating keeps req_ready at zero while reset is held.
   assign elig     = bus.req_valid & bus.ch_enable & {NUM_CH{~bus.flush & ~rst}};
   assign elig_rot = NUM_CH'({elig, elig} >> ptr);

   always_comb begin
      gnt_any = 1'b0;
      gnt_off = '0;
      for (int o = NUM_CH - 1; o >= 0; o--) begin
         if (elig_rot[o]) begin
            gnt_any = 1'b1;
            gnt_off = CH_W'(o);
         end
      end
   end

   assign gnt_sum = {1'b0, gnt_off} + {1'b0, ptr};
   assign gnt_ch  = (gnt_sum >= (CH_W+1)'(NUM_CH)) ? CH_W'(gnt_sum - (CH_W+1)'(NUM_CH))
                                                   : gnt_sum[CH_W-1:0];
   assign bus.req_ready = gnt_any ? (NUM_CH'(1) << gnt_ch) : '0;

   always_comb begin
      sel_i = '0;
      sel_q = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (gnt_ch == CH_W'(k)) begin
            sel_i = bus.req_i[k*DATA_WIDTH +: DATA_WIDTH];
            sel_q = bus.req_q[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign tag_vld_nxt = bus.flush ? '0 : {tag_vld[LATENCY-1:0], gnt_any};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr               <= '0;
         bus.dp_inphase    <= '0;
         bus.dp_quadrature <= '0;
         tag_vld           <= '0;
         for (int i = 0; i <= LATENCY; i++) tag_ch[i] <= '0;
         bus.res_valid     <= 1'b0;
         bus.res_ch        <= '0;
         bus.res_data      <= '0;
         bus.busy          <= 1'b0;
      end else begin
         if (gnt_any)
            ptr <= (gnt_ch == CH_W'(NUM_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
         bus.dp_inphase    <= gnt_any ? sel_i : '0;
         bus.dp_quadrature <= gnt_any ? sel_q : '0;
         tag_vld           <= tag_vld_nxt;
         tag_ch[0]         <= gnt_any ? gnt_ch : '0;
         for (int i = 1; i <= LATENCY; i++) tag_ch[i] <= tag_ch[i-1];
         // The last tag stage lines up with dp_result; a flush on this edge suppresses it too.
         bus.res_valid     <= tag_vld[LATENCY] & ~bus.flush;
         bus.res_ch        <= tag_ch[LATENCY];
         bus.res_data      <= bus.dp_result;
         bus.busy          <= |tag_vld_nxt;
      end
   end
endmodule

// File: tb/tb_am_demod_scheduler.sv
// Randomised and directed bench for am_demod_scheduler with a behavioural datapath and scoreboard.
module tb_am_demod_scheduler;
   localparam int DW  = 12;
   localparam int NCH = 4;
   localparam int LAT = 5;

   typedef struct {
      int ch;
      int data;
      int due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   started = 1'b0;
   int   mptr = 0;
   exp_t sb[$];

   logic signed [DW-1:0] si [NCH];
   logic signed [DW-1:0] sq [NCH];
   logic        [DW:0]   dp_pipe [LAT];

   am_demod_scheduler_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

   am_demod_scheduler #(.DATA_WIDTH(DW), .NUM_CH(NCH), .LATENCY(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int isqrt(input int v);
      int r = 0;
      for (int b = 12; b >= 0; b--) begin
         int t;
         t = r | (1 << b);
         if (t * t <= v) r = t;
      end
      return r;
   endfunction

   function automatic int mag(input int i, input int q);
      return isqrt(i * i + q * q);
   endfunction

   // Stand-in for the shared magnitude datapath: free-running, LAT register stages.
   always @(posedge clk) begin
      dp_pipe[0] <= (DW+1)'(mag(bus.dp_inphase, bus.dp_quadrature));
      for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
   end
   assign bus.dp_result = dp_pipe[LAT-1];

   task automatic check(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One cycle of stimulus: drive at negedge, predict the grant, record the expected result.
   task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] en, input logic fl);
      int g;
      @(negedge clk);
      bus.req_valid = v;
      bus.ch_enable = en;
      bus.flush     = fl;
      for (int k = 0; k < NCH; k++) begin
         bus.req_i[k*DW +: DW] = si[k];
         bus.req_q[k*DW +: DW] = sq[k];
      end
      g = -1;
      for (int o = 0; o < NCH; o++) begin
         int k;
         k = (mptr + o) % NCH;
         if (g < 0 && v[k] && en[k] && !fl) g = k;
      end
      #1;
      check("req_ready", bus.req_ready, (g >= 0) ? (1 << g) : 0);
      @(posedge clk);
      #1;
      if (g >= 0) begin
         sb.push_back('{ch: g, data: mag(si[g], sq[g]), due: cyc + LAT + 1});
         mptr = (g + 1) % NCH;
         check("dp_inphase", bus.dp_inphase, si[g]);
         check("dp_quadrature", bus.dp_quadrature, sq[g]);
      end else begin
         check("dp_inphase_idle", bus.dp_inphase, 0);
      end
      if (fl) sb.delete();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step('0, '1, 1'b0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_req_ready"}, bus.req_ready, 0);
      check({tag, "_dp_inphase"}, bus.dp_inphase, 0);
      check({tag, "_dp_quadrature"}, bus.dp_quadrature, 0);
      check({tag, "_res_valid"}, bus.res_valid, 0);
      check({tag, "_res_ch"}, bus.res_ch, 0);
      check({tag, "_res_data"}, bus.res_data, 0);
      check({tag, "_busy"}, bus.busy, 0);
   endtask

   // Monitor: pops the scoreboard whenever a result appears and tracks busy.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started && !rst) begin
            if (bus.res_valid) begin
               if (sb.size() == 0) begin
                  check("unexpected_res_valid", bus.res_valid, 0);
               end else begin
                  e = sb.pop_front();
                  check("res_ch", bus.res_ch, e.ch);
                  check("res_data", bus.res_data, e.data);
                  check("res_time", cyc, e.due);
               end
            end else if (sb.size() != 0 && sb[0].due <= cyc) begin
               e = sb.pop_front();
               check("missing_res_valid", bus.res_valid, 1);
            end
            check("busy", bus.busy, (sb.size() != 0) ? 1 : 0);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      bus.req_valid = '0;
      bus.ch_enable = '0;
      bus.flush     = 1'b0;
      bus.req_i     = '0;
      bus.req_q     = '0;
      for (int k = 0; k < NCH; k++) begin
         si[k] = '0;
         sq[k] = '0;
      end
      bus.req_valid = '1;
      bus.ch_enable = '1;
      #22;
      check_zero("reset");
      bus.req_valid = '0;
      @(negedge clk);
      rst = 1'b0;
      started = 1'b1;

      // Single channel 3-4-5
      si[0] = 12'sd3; sq[0] = 12'sd4;
      step(4'b0001, 4'b1111, 1'b0);
      idle(8);

      // Corner value on channel 2
      si[2] = -12'sd2048; sq[2] = -12'sd2048;
      step(4'b0100, 4'b1111, 1'b0);
      idle(8);

      // Full load: grants rotate 0..3
      for (int k = 0; k < NCH; k++) begin
         si[k] = DW'(k + 1);
         sq[k] = '0;
      end
      for (int i = 0; i < 8; i++) step(4'b1111, 4'b1111, 1'b0);
      idle(8);

      // Mask then fairness between ch1 and ch3
      si[1] = 12'sd100; sq[1] = -12'sd7;
      si[3] = -12'sd300; sq[3] = 12'sd400;
      for (int i = 0; i < 4; i++) step(4'b1010, 4'b0111, 1'b0);
      for (int i = 0; i < 6; i++) step(4'b1010, 4'b1111, 1'b0);
      idle(8);

      // Flush with a request pending in the same cycle
      si[0] = 12'sd6; sq[0] = 12'sd8;
      for (int i = 0; i < 3; i++) step(4'b0001, 4'b1111, 1'b0);
      step(4'b0000, 4'b1111, 1'b0);
      step(4'b0001, 4'b1111, 1'b1);
      step(4'b0001, 4'b1111, 1'b0);
      idle(8);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         logic [NCH-1:0] v, en;
         for (int k = 0; k < NCH; k++) begin
            si[k] = DW'(int'($urandom_range(0, 4095)) - 2048);
            sq[k] = DW'(int'($urandom_range(0, 4095)) - 2048);
         end
         v  = NCH'($urandom);
         en = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '1;
         step(v, en, ($urandom_range(0, 24) == 0));
      end
      idle(8);

      // Asynchronous reset with samples in flight
      for (int k = 0; k < NCH; k++) begin
         si[k] = DW'(10 * (k + 1));
         sq[k] = DW'(k);
      end
      for (int i = 0; i < 4; i++) step(4'b1111, 4'b1111, 1'b0);
      #2;
      rst = 1'b1;
      sb.delete();
      mptr = 0;
      #1;
      check_zero("midreset");
      @(posedge clk);
      #2;
      bus.req_valid = '0;
      rst = 1'b0;
      idle(10);
      step(4'b1111, 4'b1111, 1'b0);
      idle(8);

      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
